// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output block.
// Counter widths, duty encodings and output count.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] PWM_CNT_MAX = 8'hFF;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int PRESCALE_DEFAULT = 13;
  localparam int NUM_OUT = 16;

  // Full-scale duty is forced high so 0xFF has no low step.
  function automatic logic pwm_level(
    input logic [PWM_CNT_W-1:0] cnt,
    input logic [PWM_CNT_W-1:0] duty
  );
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Configuration bundle from the SPI register file to the PWM block.
// master: register file (drives), slave: pwm_peripheral (samples).
interface pwm_peripheral_if;

  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0,
    input en_reg_out_15_8,
    input en_reg_pwm_7_0,
    input en_reg_pwm_15_8,
    input pwm_duty_cycle
  );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit PWM step counter.
// Ports: clk, rst (async, low) in; tick, pwm_cnt, period_end out.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEFAULT,
  parameter int PRESCALE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 tick,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 period_end
);

  localparam logic [PRESCALE_W-1:0] PRE_LAST =
    PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] presc;

  // PRESCALE=1 pins presc at 0, so tick is constant high.
  assign tick = (presc == PRE_LAST);
  assign period_end = tick && (pwm_cnt == PWM_CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      if (tick) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
        presc   <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16 user outputs: forced low, static high or shared 8-bit PWM.
// Ports: clk, rst (async, low), cfg (slave), out[15:0], period_start.
// Build option PWM_SHADOW_EN: duty only reloads at period boundary.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEFAULT,
  parameter int PRESCALE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  pwm_peripheral_if.slave    cfg,
  output logic [NUM_OUT-1:0] out,
  output logic               period_start
);

  logic                 tick_unused;
  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic                 period_end;
  logic [PWM_CNT_W-1:0] duty_cmp;
  logic                 pwm_raw;
  logic [NUM_OUT-1:0]   en_out;
  logic [NUM_OUT-1:0]   en_pwm;
  logic [NUM_OUT-1:0]   out_nxt;

  pwm_timebase #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick_unused),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end)
  );

  assign en_out = {cfg.en_reg_out_15_8, cfg.en_reg_out_7_0};
  assign en_pwm = {cfg.en_reg_pwm_15_8, cfg.en_reg_pwm_7_0};

`ifdef PWM_SHADOW_EN
  logic [PWM_CNT_W-1:0] duty_active;

  // Reload only at the wrap so a period is never cut short.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_active <= '0;
    end else if (period_end) begin
      duty_active <= cfg.pwm_duty_cycle;
    end
  end

  assign duty_cmp = duty_active;
`else
  assign duty_cmp = cfg.pwm_duty_cycle;
`endif

  assign pwm_raw = pwm_level(pwm_cnt, duty_cmp);

  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      unique case (1'b1)
        !en_out[i]:
          out_nxt[i] = 1'b0;
        en_out[i] && !en_pwm[i]:
          out_nxt[i] = 1'b1;
        en_out[i] && en_pwm[i]:
          out_nxt[i] = pwm_raw;
        default:
          out_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_nxt;
      period_start <= period_end;
    end
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 user outputs. Each output is forced low, held static high, or driven with a shared 8-bit PWM waveform. Sits directly downstream of the SPI register file in the same clk domain. No synchronisers are needed on its inputs.

Parameters:
PRESCALE, 13, system clocks per PWM count step (10 MHz clk gives ~3.0 kHz PWM); legal range 1..65535
PRESCALE_W, 16, width of the prescaler counter; must satisfy 2^PRESCALE_W >= PRESCALE

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
en_reg_out_7_0  input  8  output enable, bits 7..0
en_reg_out_15_8  input  8  output enable, bits 15..8
en_reg_pwm_7_0  input  8  PWM mode select, bits 7..0
en_reg_pwm_15_8  input  8  PWM mode select, bits 15..8
pwm_duty_cycle  input  8  requested duty; 0x00 = 0 %, 0xFF = 100 %
out  output  16  user outputs, registered
period_start  output  1  one-clk pulse at the start of each PWM period, registered

Behaviour:
- Reset (rst low, async): out=16'h0000, period_start=0, prescaler=0, pwm_cnt=0, duty_active=0x00. Reset may assert mid-period; all state clears immediately.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 on the cycle the prescaler equals PRESCALE-1. With PRESCALE=1, tick=1 every cycle.
- pwm_cnt: 8-bit, increments on tick, wraps 255->0. Period is 256*PRESCALE clocks.
- Period boundary: the cycle where tick=1 and pwm_cnt=255.
  - duty_active <= pwm_duty_cycle (shadow load).
  - period_start <= 1 for exactly one clk; otherwise 0.
- Raw waveform:
  - pwm_raw = 1 if duty_active==0xFF.
  - Otherwise pwm_raw = (pwm_cnt < duty_active).
  - duty 0x00 gives constant 0. duty 0x80 gives 128 of 256 steps high. 0xFF gives constant 1, with no 1-step glitch.
- Per output i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - en_out[i]=0 -> out[i] <= 0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0 -> out[i] <= 1.
  - en_out[i]=1, en_pwm[i]=1 -> out[i] <= pwm_raw.
- Latency:
  - Enable/mode changes appear on out exactly 1 clk after the input changes.
  - pwm_raw appears on out 1 clk after the pwm_cnt value that produced it.
- Duty changes mid-period are ignored until the next period boundary, so there are no runt or stretched pulses.
- Duty written on the exact boundary cycle is captured at that boundary.
- All PWM-mode outputs share one phase. Rising edges are aligned to the cycle after period_start.
- Enable inputs are sampled every clk. No handshake; inputs are static registers from the upstream block.

Optional Feature:
PWM_SHADOW_EN
- Defined: duty_active is loaded only at the period boundary, as above.
- Undefined: duty_active is not instantiated. pwm_raw compares directly against pwm_duty_cycle, so a new duty takes effect on the next clk. Glitches at the change point are permitted. All other behaviour is identical.

Decomposition:
- Package pwm_pkg: PWM_CNT_W=8, PWM_CNT_MAX=8'hFF, DUTY_FULL=8'hFF, PRESCALE_DEFAULT=13, NUM_OUT=16.
- Sub-module pwm_timebase (PRESCALE, PRESCALE_W): prescaler plus pwm_cnt; outputs tick, pwm_cnt, period_end.
- Top module holds the duty shadow, per-bit mux and output registers.

Test Plan:
1. Reset, then en_out=16'hFFFF, en_pwm=0 -> out=16'hFFFF exactly 1 clk later; en_out=0 -> out=0 1 clk later.
2. PRESCALE=2, en_out=en_pwm=16'h0001, duty=0x80 -> out[0] high 256 clks, low 256 clks per 512-clk period; out[15:1]=0; period_start pulses every 512 clks.
3. Duty 0x00 and 0xFF with out[0] in PWM mode, over 3 periods -> constant 0, then constant 1, with no single-cycle glitch at any wrap.
4. PWM_SHADOW_EN defined, duty changed 0x40->0xC0 at pwm_cnt=0x20 -> current period keeps 64-step high time; next period (after period_start) has 192-step high time. Undefined -> change takes effect the next clk.
5. Assert rst at pwm_cnt=0x90 with duty=0xFF -> out=0 and period_start=0 immediately (async). After release, pwm_cnt restarts at 0 and duty_active=0, so out stays low until the first boundary loads the duty.
6. Mixed config: en_out=16'hF0F0, en_pwm=16'hFF00, duty=0x40 -> bits 15:12 PWM at 25 %, bits 7:4 static high, all other bits 0; bits 15:12 in phase.
